// File: rtl/ast_sw_debounce_if.sv
// Switch/pushbutton conditioning bus: raw board pins in, clean levels,
// rise pulses and the acknowledged button flag out.
interface ast_sw_debounce_if;
    logic [4:0] SW_raw;
    logic [4:0] SW_clean;
    logic [4:0] SW_rise;
    logic       Btn_event;
    logic       Btn_ack;

    modport master (
        output SW_raw,
        output Btn_ack,
        input  SW_clean,
        input  SW_rise,
        input  Btn_event
    );

    modport slave (
        input  SW_raw,
        input  Btn_ack,
        output SW_clean,
        output SW_rise,
        output Btn_event
    );
endinterface

// File: rtl/ast_sw_debounce.sv
// Two-flop synchroniser plus per-bit stability-counter debounce for the five board inputs.
// Define AST_SW_EDGE_EN to build the rise-pulse registers and the sticky button flag.
module ast_sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic              Clock_pin,
    input  logic              Resetn_pin,
    ast_sw_debounce_if.slave  sw
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       sync1_q, sync2_q;
    logic [4:0]       clean_q, clean_d;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= sw.SW_raw;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // A bit only flips after sync2 has disagreed with it for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    clean_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign sw.SW_clean = clean_q;

`ifdef AST_SW_EDGE_EN
    logic [4:0] rise_q, rise_d;
    logic       btn_q, btn_d;

    always_comb begin
        rise_d = clean_d & ~clean_q;
        btn_d  = btn_q;
        // A new press wins over a simultaneous ack so no event is dropped.
        if (rise_d[4]) begin
            btn_d = 1'b1;
        end else if (sw.Btn_ack) begin
            btn_d = 1'b0;
        end
    end

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            rise_q <= '0;
            btn_q  <= 1'b0;
        end else begin
            rise_q <= rise_d;
            btn_q  <= btn_d;
        end
    end

    assign sw.SW_rise   = rise_q;
    assign sw.Btn_event = btn_q;
`else
    logic unused_btn_ack;
    assign unused_btn_ack = sw.Btn_ack;
    assign sw.SW_rise     = 5'b0;
    assign sw.Btn_event   = 1'b0;
`endif

endmodule

// File: tb/tb_ast_sw_debounce.sv
// Directed bench for ast_sw_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
// Expected edge/flag values follow whether AST_SW_EDGE_EN is defined for this build.
module tb_ast_sw_debounce;

`ifdef AST_SW_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ast_sw_debounce_if sw_if ();

    ast_sw_debounce #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .Clock_pin  (clk),
        .Resetn_pin (rst_n),
        .sw         (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs are driven and outputs sampled at the falling edge.
    task automatic step(input int n);
        for (int s = 0; s < n; s++) @(negedge clk);
    endtask

    task automatic chk5(input string name, input int k, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d: got %b expected %b", name, k, got, exp);
        end
    endtask

    task automatic chk1(input string name, input int k, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d: got %b expected %b", name, k, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        sw_if.SW_raw = 5'b0;
        sw_if.Btn_ack = 1'b0;
        step(2);
        chk5("reset_clean", 0, sw_if.SW_clean, 5'b0);
        chk5("reset_rise", 0, sw_if.SW_rise, 5'b0);
        chk1("reset_btn", 0, sw_if.Btn_event, 1'b0);
        rst_n = 1'b1;
        step(2);
        chk5("post_reset_clean", 0, sw_if.SW_clean, 5'b0);
    endtask

    task automatic test_basic_rise();
        sw_if.SW_raw = 5'b00001;
        for (int k = 0; k <= 7; k++) begin
            step(1);
            chk5("basic_clean", k, sw_if.SW_clean, (k >= 5) ? 5'b00001 : 5'b00000);
            chk5("basic_rise", k, sw_if.SW_rise, (EDGE_EN && k == 5) ? 5'b00001 : 5'b00000);
            chk1("basic_btn", k, sw_if.Btn_event, 1'b0);
        end
    endtask

    task automatic test_glitch();
        sw_if.SW_raw = 5'b00101;
        for (int k = 0; k <= 9; k++) begin
            step(1);
            if (k == 2) sw_if.SW_raw = 5'b00001;
            chk5("glitch3_clean", k, sw_if.SW_clean, 5'b00001);
            chk5("glitch3_rise", k, sw_if.SW_rise, 5'b00000);
        end
        sw_if.SW_raw = 5'b00101;
        for (int k = 0; k <= 11; k++) begin
            step(1);
            if (k == 3) sw_if.SW_raw = 5'b00001;
            chk5("glitch4_clean", k, sw_if.SW_clean,
                 (k >= 5 && k <= 8) ? 5'b00101 : 5'b00001);
            chk5("glitch4_rise", k, sw_if.SW_rise,
                 (EDGE_EN && k == 5) ? 5'b00100 : 5'b00000);
        end
    endtask

    task automatic test_button();
        sw_if.SW_raw = 5'b10001;
        for (int k = 0; k <= 7; k++) begin
            step(1);
            chk1("btn_set", k, sw_if.Btn_event, EDGE_EN && k >= 5);
        end
        chk5("btn_clean", 0, sw_if.SW_clean, 5'b10001);
        sw_if.Btn_ack = 1'b1;
        step(1);
        sw_if.Btn_ack = 1'b0;
        chk1("btn_ack_clear", 0, sw_if.Btn_event, 1'b0);
        step(2);
        chk1("btn_ack_hold", 0, sw_if.Btn_event, 1'b0);
        sw_if.SW_raw = 5'b00001;
        step(8);
        chk5("btn_release_clean", 0, sw_if.SW_clean, 5'b00001);
        chk1("btn_release_flag", 0, sw_if.Btn_event, 1'b0);
        sw_if.SW_raw = 5'b10001;
        for (int k = 0; k <= 6; k++) begin
            step(1);
            chk1("btn_repress", k, sw_if.Btn_event, EDGE_EN && k >= 5);
            chk5("btn_repress_rise", k, sw_if.SW_rise, (EDGE_EN && k == 5) ? 5'b10000 : 5'b00000);
        end
    endtask

    task automatic test_collision();
        sw_if.SW_raw  = 5'b00001;
        sw_if.Btn_ack = 1'b1;
        step(1);
        sw_if.Btn_ack = 1'b0;
        step(8);
        chk1("coll_pre_clear", 0, sw_if.Btn_event, 1'b0);
        sw_if.SW_raw = 5'b10001;
        step(5);
        chk1("coll_before", 0, sw_if.Btn_event, 1'b0);
        sw_if.Btn_ack = 1'b1;
        step(1);
        chk5("coll_rise", 0, sw_if.SW_rise, EDGE_EN ? 5'b10000 : 5'b00000);
        chk1("coll_set_wins", 0, sw_if.Btn_event, EDGE_EN);
        sw_if.Btn_ack = 1'b0;
        step(1);
        chk1("coll_after", 1, sw_if.Btn_event, EDGE_EN);
    endtask

    task automatic test_reset_mid();
        sw_if.SW_raw = 5'b11111;
        step(3);
        #1;
        rst_n = 1'b0;
        #1;
        chk5("rstmid_clean", 0, sw_if.SW_clean, 5'b0);
        chk5("rstmid_rise", 0, sw_if.SW_rise, 5'b0);
        chk1("rstmid_btn", 0, sw_if.Btn_event, 1'b0);
        step(2);
        rst_n = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            step(1);
            chk5("rstmid_relclean", k, sw_if.SW_clean, (k >= 5) ? 5'b11111 : 5'b00000);
            chk5("rstmid_relrise", k, sw_if.SW_rise, (EDGE_EN && k == 5) ? 5'b11111 : 5'b00000);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sw_if.SW_raw  = 5'b0;
        sw_if.Btn_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_rise();
        test_glitch();
        test_button();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
